note_sequencer: RTL
===================

Name: note_sequencer

Overview:
- Step sequencer that drives the control inputs of one synth voice: pitch_increment, gate, and step position.
- Plays a pattern from an internal step RAM, which the CPU side loads through a write port on the same clock.
- Converts MIDI note numbers to phase increments with the voice's phase-accumulator scaling.
- Times steps with a programmable tick divider, prefetching the next step so step boundaries have no gaps.

Parameters:
- BITDEPTH, 14, oscillator output bit depth (sets increment scaling)
- BITFRACTION, 8, oscillator phase fraction bits (sets increment scaling)
- SAMPLEFREQ, 48000, sample_clock rate in Hz, used only at elaboration
- STEPS, 16, step RAM depth (power of two, ≥2); AW = log2(STEPS)

Ports:
- sample_clock  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  step RAM write strobe
- wr_addr  in  AW  step RAM write address
- wr_data  in  16  step word: [15] rest, [14:8] MIDI note, [7:0] duration in ticks (0 = end-of-pattern marker)
- start  in  1  pulse: (re)start the pattern at step 0
- stop  in  1  pulse: halt playback
- tick_div  in  16  one tick every tick_div+1 cycles
- gate_len  in  8  ticks per step that gate is held high
- pitch_increment  out  16  to the voice oscillator
- gate  out  1  to the voice envelope
- step_index  out  AW  index of the step now playing
- step_strobe  out  1  one-cycle pulse on each step load
- running  out  1  high while playing

Behaviour:
- Reset: pitch_increment=0, gate=0, step_index=0, step_strobe=0, running=0, state=IDLE, counters=0. RAM contents are not reset.
- RAM: synchronous write, synchronous read with 1-cycle latency. Writes are accepted in every state.
- States:
  - IDLE: outputs hold, except gate=0.
  - FETCH0: address is issued.
  - FETCH1: data is captured.
  - PLAY: ticking.
- start (any state) → FETCH0 at address 0 → FETCH1 → first step load on the next cycle. The load is 3 cycles after the start cycle.
- Step load (registered, one cycle):
  - step_index, pitch_increment and gate update; step_strobe=1; running=1.
  - Divider count and tick count clear to 0.
  - A prefetch of the next address ((index+1) mod STEPS) starts.
- Rest step: gate=0, pitch_increment holds its previous value.
- Non-rest step: gate = (gate_len != 0).
- Tick: the divider counts 0..tick_div, and the tick fires on the cycle where count == tick_div. tick_div=0 means a tick every cycle.
- Ticks elapsed t increments on each tick.
- gate falls on the tick where t+1 == gate_len.
- The step ends on the tick where t+1 == duration, and the prefetched step loads on the next cycle.
- Step period is exactly duration·(tick_div+1) cycles.
- gate_len ≥ duration gives legato: gate stays high into the next non-rest step, with no low cycle.
- Prefetch marker: if the prefetched word has duration 0, fetch address 0 instead (2 more cycles).
- If step 0 itself has duration 0, playback goes to IDLE with running=0 and gate=0. This check applies both at start and at wrap.
- If the prefetch is not ready when the step ends (period < 5 cycles), the load stalls until the prefetch completes, and gate/pitch hold.
- Writes to the playing step do not affect it. Writes to the already-prefetched address are seen on the next pass.
- stop: next cycle state=IDLE, gate=0, running=0. pitch_increment and step_index hold.
- start and stop in the same cycle: stop wins.
- rst overrides everything, including mid-step operation.
- Pitch mapping:
  - o = note/12, k = note%12.
  - base[k] = round(f(48+k)·2^(BITDEPTH+BITFRACTION+1)/SAMPLEFREQ), where f(n) = 440·2^((n−69)/12). base is computed at elaboration.
  - o ≥ 4: base[k] << (o−4), saturated to 0xFFFF.
  - o < 4: base[k] >> (4−o), truncated.
  - With defaults: base[0]=22861, base[9]=38448.
  - The mapping is combinational from the fetched word and is registered at step load.

Test Plan:
- Reset, then idle 10 cycles → all outputs 0, running=0.
- Write step0={0,57,4}, step1={0,60,2}, step2 duration 0; tick_div=9, gate_len=2; pulse start at cycle 0 →
  - load at cycle 3: pitch=38448, gate=1, step_strobe=1.
  - gate falls at cycle 23.
  - step1 loads at cycle 43: pitch=45722.
  - step0 reloads at cycle 63.
- Rest step {1,any,3} after note 45 (pitch 19224) → gate=0 for the whole step, pitch stays 19224.
- Note 69 → 0xFFFF (saturation). Note 9 → 38448>>4 = 2403.
- gate_len=255 with durations 4 → gate never drops across a step boundary.
- start and stop in the same cycle while running → IDLE, gate=0.
- step0 duration 0 + start → running stays 0.
- Write to the playing step mid-step → no change until the next pass.
- tick_div=0, duration=1 → steps load every 5 cycles (stall).

Source files
------------

// File: rtl/note_sequencer.sv
// Step sequencer for one synth voice: plays a pattern from a step RAM, maps MIDI
// notes to oscillator phase increments, and prefetches the next step so steps abut.
module note_sequencer #(
    parameter int BITDEPTH    = 14,
    parameter int BITFRACTION = 8,
    parameter int SAMPLEFREQ  = 48000,
    parameter int STEPS       = 16,
    localparam int AW         = $clog2(STEPS)
) (
    input  logic          sample_clock,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic          start,
    input  logic          stop,
    input  logic [15:0]   tick_div,
    input  logic [7:0]    gate_len,
    output logic [15:0]   pitch_increment,
    output logic          gate,
    output logic [AW-1:0] step_index,
    output logic          step_strobe,
    output logic          running
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH0 = 2'd1,
        S_FETCH1 = 2'd2,
        S_PLAY   = 2'd3
    } state_t;

    // Increment for the octave starting at MIDI 48, scaled to the phase accumulator.
    function automatic int calc_base(input int k);
        real freq;
        real scale;
        freq = 130.8127826502993;
        for (int i = 0; i < k; i++) begin
            freq = freq * 1.0594630943592953;
        end
        scale = 1.0;
        for (int i = 0; i < BITDEPTH + BITFRACTION + 1; i++) begin
            scale = scale * 2.0;
        end
        return $rtoi(freq * scale / SAMPLEFREQ + 0.5);
    endfunction

    logic [15:0] base_tbl [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_base
        if (gi < 12) begin : g_note
            localparam int BASE_V = calc_base(gi);
            assign base_tbl[gi] = BASE_V[15:0];
        end else begin : g_pad
            assign base_tbl[gi] = 16'd0;
        end
    end

    // Step RAM: read-first, one cycle read latency, contents never reset.
    logic [15:0]   mem [STEPS];
    logic [15:0]   rd_q;
    logic [AW-1:0] rd_addr;

    always_ff @(posedge sample_clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

    state_t        state_q, state_d;
    logic [15:0]   pitch_q, pitch_d;
    logic          gate_q, gate_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          strobe_q, strobe_d;
    logic          running_q, running_d;
    logic [15:0]   div_q, div_d;
    logic [7:0]    tick_q, tick_d;
    logic [7:0]    dur_q, dur_d;
    logic [AW-1:0] pf_addr_q, pf_addr_d;
    logic [2:0]    pf_cnt_q, pf_cnt_d;
    logic [15:0]   pf_word_q, pf_word_d;
    logic          redirect_q, redirect_d;
    logic          ended_q, ended_d;

    logic [15:0]   load_word;
    logic [AW-1:0] load_idx;
    logic [6:0]    note_w, oct_w, semi_w;
    logic [15:0]   base_w;
    logic [31:0]   shl_w;
    logic [15:0]   mapped_w;
    logic [8:0]    tick_inc;
    logic          step_end;
    logic          do_load;

    assign load_word = (state_q == S_FETCH1) ? rd_q : pf_word_q;
    assign load_idx  = (state_q == S_FETCH1) ? '0 : pf_addr_q;
    assign tick_inc  = {1'b0, tick_q} + 9'd1;

    always_comb begin
        note_w = load_word[14:8];
        oct_w  = note_w / 7'd12;
        semi_w = note_w % 7'd12;
        base_w = base_tbl[semi_w[3:0]];
        shl_w  = {16'd0, base_w} << (oct_w - 7'd4);
        if (oct_w >= 7'd4) begin
            mapped_w = (|shl_w[31:16]) ? 16'hFFFF : shl_w[15:0];
        end else begin
            mapped_w = base_w >> (7'd4 - oct_w);
        end
    end

    always_ff @(posedge sample_clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pitch_q    <= '0;
            gate_q     <= 1'b0;
            idx_q      <= '0;
            strobe_q   <= 1'b0;
            running_q  <= 1'b0;
            div_q      <= '0;
            tick_q     <= '0;
            dur_q      <= '0;
            pf_addr_q  <= '0;
            pf_cnt_q   <= '0;
            pf_word_q  <= '0;
            redirect_q <= 1'b0;
            ended_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pitch_q    <= pitch_d;
            gate_q     <= gate_d;
            idx_q      <= idx_d;
            strobe_q   <= strobe_d;
            running_q  <= running_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            dur_q      <= dur_d;
            pf_addr_q  <= pf_addr_d;
            pf_cnt_q   <= pf_cnt_d;
            pf_word_q  <= pf_word_d;
            redirect_q <= redirect_d;
            ended_q    <= ended_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pitch_d    = pitch_q;
        gate_d     = gate_q;
        idx_d      = idx_q;
        strobe_d   = 1'b0;
        running_d  = running_q;
        div_d      = div_q;
        tick_d     = tick_q;
        dur_d      = dur_q;
        pf_addr_d  = pf_addr_q;
        pf_cnt_d   = pf_cnt_q;
        pf_word_d  = pf_word_q;
        redirect_d = redirect_q;
        ended_d    = ended_q;
        rd_addr    = pf_addr_q;
        step_end   = 1'b0;
        do_load    = 1'b0;

        if (stop) begin
            state_d   = S_IDLE;
            gate_d    = 1'b0;
            running_d = 1'b0;
        end else if (start) begin
            state_d = S_FETCH0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    gate_d = 1'b0;
                end
                S_FETCH0: begin
                    rd_addr = '0;
                    state_d = S_FETCH1;
                end
                S_FETCH1: begin
                    do_load = 1'b1;
                end
                S_PLAY: begin
                    // Fixed 4-cycle prefetch; slot 2 redirects to step 0 on an end marker.
                    case (pf_cnt_q)
                        3'd0: rd_addr = pf_addr_q;
                        3'd1: pf_word_d = rd_q;
                        3'd2: begin
                            if (pf_word_q[7:0] == 8'd0) begin
                                rd_addr    = '0;
                                pf_addr_d  = '0;
                                redirect_d = 1'b1;
                            end
                        end
                        3'd3: begin
                            if (redirect_q) begin
                                pf_word_d = rd_q;
                            end
                        end
                        default: ;
                    endcase
                    if (pf_cnt_q != 3'd4) begin
                        pf_cnt_d = pf_cnt_q + 3'd1;
                    end

                    if (!ended_q) begin
                        if (div_q == tick_div) begin
                            div_d  = '0;
                            tick_d = tick_q + 8'd1;
                            if (tick_inc == {1'b0, gate_len}) begin
                                gate_d = 1'b0;
                            end
                            if (tick_inc == {1'b0, dur_q}) begin
                                step_end = 1'b1;
                            end
                        end else begin
                            div_d = div_q + 16'd1;
                        end
                    end

                    // A finished step waits here, outputs frozen, until the prefetch lands.
                    if (step_end || ended_q) begin
                        if (pf_cnt_q == 3'd4) begin
                            do_load = 1'b1;
                        end else begin
                            ended_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (do_load) begin
            if (load_word[7:0] == 8'd0) begin
                state_d   = S_IDLE;
                running_d = 1'b0;
                gate_d    = 1'b0;
            end else begin
                state_d    = S_PLAY;
                idx_d      = load_idx;
                strobe_d   = 1'b1;
                running_d  = 1'b1;
                div_d      = '0;
                tick_d     = '0;
                dur_d      = load_word[7:0];
                pf_addr_d  = load_idx + AW'(1);
                pf_cnt_d   = '0;
                redirect_d = 1'b0;
                ended_d    = 1'b0;
                if (load_word[15]) begin
                    gate_d = 1'b0;
                end else begin
                    pitch_d = mapped_w;
                    gate_d  = (gate_len != 8'd0);
                end
            end
        end
    end

    assign pitch_increment = pitch_q;
    assign gate            = gate_q;
    assign step_index      = idx_q;
    assign step_strobe     = strobe_q;
    assign running         = running_q;

endmodule
